// File: rtl/memmu_sr_payload_writer.sv
// Payload FIFO that drains into fixed-length write bursts at an auto-advancing frame pointer.
// Optional statistics counters are compiled in with MEMMU_SR_PW_STATS_EN.
module memmu_sr_payload_writer #(
  parameter int FIFO_DEPTH = 16,
  parameter int BURST_LEN  = 8,
  parameter int ADDR_W     = 32
) (
  input  logic              i_SYSTEM_clk,
  input  logic              i_SYSTEM_rst,
  input  logic [63:0]       i_MemMU_SR_P_payload,
  input  logic              i_MemMU_SR_P_valid,
  output logic              o_MemMU_SR_PW_ready,
  input  logic [ADDR_W-1:0] i_MemMU_SR_PW_baseAddr,
  input  logic              i_MemMU_SR_PW_frameStart,
  input  logic              i_MemMU_SR_PW_flush,
  output logic              o_MemMU_SR_PW_flushDone,
  output logic [ADDR_W-1:0] o_MEM_awaddr,
  output logic [7:0]        o_MEM_awlen,
  output logic              o_MEM_awvalid,
  input  logic              i_MEM_awready,
  output logic [63:0]       o_MEM_wdata,
  output logic              o_MEM_wlast,
  output logic              o_MEM_wvalid,
  input  logic              i_MEM_wready,
  output logic [31:0]       o_MemMU_SR_PW_beatCount,
  output logic [15:0]       o_MemMU_SR_PW_burstCount
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(BURST_LEN) + 1;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

  state_e            state_q, state_d;
  logic [63:0]       mem_q [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic              rdy_en_q;
  logic [BW-1:0]     beats_q, beats_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [ADDR_W-1:0] fs_base_q, fs_base_d;
  logic              fs_pend_q, fs_pend_d;
  logic              flush_pend_q, flush_pend_d;
  logic              push, pop, burst_go, last_beat;
  logic [BW-1:0]     beats_min;

  // rdy_en_q keeps ready low until the first clock after reset release
  assign o_MemMU_SR_PW_ready = rdy_en_q && (count_q != CW'(FIFO_DEPTH));
  assign push      = i_MemMU_SR_P_valid && o_MemMU_SR_PW_ready;
  assign pop       = (state_q == DATA) && i_MEM_wready;
  assign last_beat = pop && o_MEM_wlast;

  always_ff @(posedge i_SYSTEM_clk) begin
    if (push) mem_q[wr_ptr_q] <= i_MemMU_SR_P_payload;
  end

  always_ff @(posedge i_SYSTEM_clk) begin
    if (!i_SYSTEM_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign burst_go  = (count_q >= CW'(BURST_LEN)) || (flush_pend_q && (count_q != '0));
  assign beats_min = (count_q >= CW'(BURST_LEN)) ? BW'(BURST_LEN) : BW'(count_q);

  assign o_MemMU_SR_PW_flushDone = (state_q == IDLE) && flush_pend_q && (count_q == '0);

  always_comb begin
    state_d   = state_q;
    beats_d   = beats_q;
    beat_d    = beat_q;
    waddr_d   = waddr_q;
    fs_pend_d = fs_pend_q;
    fs_base_d = fs_base_q;
    unique case (state_q)
      IDLE: begin
        if (i_MemMU_SR_PW_frameStart) begin
          waddr_d   = i_MemMU_SR_PW_baseAddr;
          fs_pend_d = 1'b0;
        end else if (fs_pend_q) begin
          waddr_d   = fs_base_q;
          fs_pend_d = 1'b0;
        end
        if (burst_go) begin
          state_d = ADDR;
          beats_d = beats_min;
          beat_d  = '0;
        end
      end
      ADDR: if (i_MEM_awready) state_d = DATA;
      DATA: begin
        if (pop) begin
          beat_d = beat_q + BW'(1);
          if (o_MEM_wlast) begin
            state_d = IDLE;
            waddr_d = waddr_q + ADDR_W'({beats_q, 3'b000});
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // A frame restart during a burst waits so the burst finishes at its old address
    if ((state_q != IDLE) && i_MemMU_SR_PW_frameStart) begin
      fs_pend_d = 1'b1;
      fs_base_d = i_MemMU_SR_PW_baseAddr;
    end
  end

  always_comb begin
    flush_pend_d = flush_pend_q;
    if (i_MemMU_SR_PW_flush)          flush_pend_d = 1'b1;
    else if (o_MemMU_SR_PW_flushDone) flush_pend_d = 1'b0;
  end

  always_ff @(posedge i_SYSTEM_clk) begin
    if (!i_SYSTEM_rst) begin
      state_q      <= IDLE;
      beats_q      <= '0;
      beat_q       <= '0;
      waddr_q      <= '0;
      fs_pend_q    <= 1'b0;
      fs_base_q    <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      beats_q      <= beats_d;
      beat_q       <= beat_d;
      waddr_q      <= waddr_d;
      fs_pend_q    <= fs_pend_d;
      fs_base_q    <= fs_base_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  assign o_MEM_awvalid = (state_q == ADDR);
  assign o_MEM_awaddr  = waddr_q;
  assign o_MEM_awlen   = 8'(beats_q - BW'(1));
  assign o_MEM_wvalid  = (state_q == DATA);
  assign o_MEM_wdata   = mem_q[rd_ptr_q];
  assign o_MEM_wlast   = (state_q == DATA) && (beat_q == beats_q - BW'(1));

`ifdef MEMMU_SR_PW_STATS_EN
  logic [31:0] beat_cnt_q;
  logic [15:0] burst_cnt_q;
  logic        stats_clr;

  // Cleared when a frame restart actually reloads the pointer
  assign stats_clr = (state_q == IDLE) && (i_MemMU_SR_PW_frameStart || fs_pend_q);

  always_ff @(posedge i_SYSTEM_clk) begin
    if (!i_SYSTEM_rst || stats_clr) begin
      beat_cnt_q  <= '0;
      burst_cnt_q <= '0;
    end else begin
      if (pop)       beat_cnt_q  <= beat_cnt_q + 32'd1;
      if (last_beat) burst_cnt_q <= burst_cnt_q + 16'd1;
    end
  end

  assign o_MemMU_SR_PW_beatCount  = beat_cnt_q;
  assign o_MemMU_SR_PW_burstCount = burst_cnt_q;
`else
  logic unused_last_beat;
  assign unused_last_beat         = last_beat;
  assign o_MemMU_SR_PW_beatCount  = '0;
  assign o_MemMU_SR_PW_burstCount = '0;
`endif

endmodule

// File: tb/tb_memmu_sr_payload_writer.sv
// Randomized + directed bench for memmu_sr_payload_writer against a queue-based burst model.
module tb_memmu_sr_payload_writer;
  localparam int FD = 16;
  localparam int BL = 8;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [63:0]   payload = '0;
  logic          valid = 1'b0;
  logic          ready;
  logic [AW-1:0] base = '0;
  logic          fs = 1'b0;
  logic          flush = 1'b0;
  logic          flush_done;
  logic [AW-1:0] awaddr;
  logic [7:0]    awlen;
  logic          awvalid;
  logic          awready = 1'b1;
  logic [63:0]   wdata;
  logic          wlast;
  logic          wvalid;
  logic          wready = 1'b1;
  logic [31:0]   beat_cnt;
  logic [15:0]   burst_cnt;

  memmu_sr_payload_writer #(.FIFO_DEPTH(FD), .BURST_LEN(BL), .ADDR_W(AW)) dut (
    .i_SYSTEM_clk(clk), .i_SYSTEM_rst(rst_n),
    .i_MemMU_SR_P_payload(payload), .i_MemMU_SR_P_valid(valid), .o_MemMU_SR_PW_ready(ready),
    .i_MemMU_SR_PW_baseAddr(base), .i_MemMU_SR_PW_frameStart(fs),
    .i_MemMU_SR_PW_flush(flush), .o_MemMU_SR_PW_flushDone(flush_done),
    .o_MEM_awaddr(awaddr), .o_MEM_awlen(awlen), .o_MEM_awvalid(awvalid), .i_MEM_awready(awready),
    .o_MEM_wdata(wdata), .o_MEM_wlast(wlast), .o_MEM_wvalid(wvalid), .i_MEM_wready(wready),
    .o_MemMU_SR_PW_beatCount(beat_cnt), .o_MemMU_SR_PW_burstCount(burst_cnt)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: queue of accepted payloads, current frame pointer, burst bookkeeping
  logic [63:0]   mq [$];
  logic [AW-1:0] aw_log [$];
  logic [AW-1:0] m_ptr = '0, m_fs_base = '0, last_awaddr = '0;
  bit            m_fs_def = 0, m_in_burst = 0, m_flush = 0, mon_en = 0;
  int            m_left = 0, m_len = 0, last_len = 0, occ = 0;
  int            n_bursts = 0, n_done = 0, m_beats = 0, m_bursts = 0;
  int unsigned   last_wlast_cyc = 0, last_done_cyc = 0;

  task automatic model_apply(input logic [AW-1:0] b);
    m_ptr    = b;
    m_fs_def = 0;
    m_beats  = 0;
    m_bursts = 0;
  endtask

  task automatic model_clear();
    mq.delete();
    m_ptr = '0; m_fs_def = 0; m_in_burst = 0; m_flush = 0;
    m_beats = 0; m_bursts = 0;
  endtask

  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      occ = mq.size();
      chk("ready", ready, occ != FD);
      if (flush_done) begin
        chk("fd_empty", occ, 0);
        chk("fd_pending", m_flush, 1);
        chk("fd_idle", m_in_burst || awvalid, 0);
        m_flush = 0;
        n_done++;
        last_done_cyc = cyc;
      end
      if (flush) m_flush = 1;
      if (fs) begin
        if (awvalid || m_in_burst) begin m_fs_def = 1; m_fs_base = base; end
        else model_apply(base);
      end
      if (awvalid && awready) begin
        chk("awaddr", awaddr, m_ptr);
        if (!m_flush) chk("awlen", awlen, BL - 1);
        else chk("awlen_flush", ((int'(awlen) + 1) <= occ) && (int'(awlen) < BL), 1);
        m_in_burst = 1;
        m_len  = int'(awlen) + 1;
        m_left = m_len;
        last_awaddr = awaddr;
        last_len    = int'(awlen);
        aw_log.push_back(awaddr);
      end
      if (wvalid && wready) begin
        chk("w_in_burst", m_in_burst, 1);
        if (mq.size() == 0) chk("w_underflow", 0, 1);
        else chk("wdata", wdata, mq.pop_front());
        m_left--;
        m_beats++;
        chk("wlast", wlast, m_left == 0);
        if (m_left == 0) begin
          m_in_burst = 0;
          m_ptr = m_ptr + AW'(m_len * 8);
          n_bursts++;
          m_bursts++;
          last_wlast_cyc = cyc;
          if (m_fs_def) model_apply(m_fs_base);
        end
      end
      if (valid && ready) mq.push_back(payload);
    end
  end

  task automatic chk_stats(input string tag);
`ifdef MEMMU_SR_PW_STATS_EN
    chk({tag, "_beats"}, beat_cnt, m_beats);
    chk({tag, "_bursts"}, burst_cnt, m_bursts);
`else
    chk({tag, "_beats"}, beat_cnt, 0);
    chk({tag, "_bursts"}, burst_cnt, 0);
`endif
  endtask

  task automatic push(input logic [63:0] d);
    int c = 0;
    valid = 1; payload = d;
    forever begin
      @(negedge clk);
      if (ready) break;
      if (++c > 500) begin chk("push_timeout", 0, 1); break; end
    end
    @(posedge clk); #1;
    valid = 0;
  endtask

  task automatic pulse_fs(input logic [AW-1:0] b);
    base = b; fs = 1;
    @(posedge clk); #1;
    fs = 0;
  endtask

  task automatic pulse_flush();
    flush = 1;
    @(posedge clk); #1;
    flush = 0;
  endtask

  task automatic wait_bursts(input int target, input int maxc);
    int c = 0;
    while (n_bursts < target && c < maxc) begin @(posedge clk); c++; end
    #1;
    if (n_bursts < target) chk("burst_timeout", n_bursts, target);
  endtask

  task automatic wait_done(input int target, input int maxc);
    int c = 0;
    while (n_done < target && c < maxc) begin @(posedge clk); c++; end
    #1;
    if (n_done < target) chk("flushdone_timeout", n_done, target);
  endtask

  task automatic do_reset();
    mon_en = 0; rst_n = 0; valid = 0; fs = 0; flush = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready_low", ready, 0);
    rst_n = 1;
    model_clear();
    @(posedge clk); #1;
    mon_en = 1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int b0;
    int unsigned cf;
    do_reset();
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_wlast", wlast, 0);
    chk("rst_flushdone", flush_done, 0);
    chk("rst_ready", ready, 1);
    chk_stats("rst");

    // single full burst in order
    pulse_fs(32'h1000);
    for (int i = 1; i <= 8; i++) push(64'h0 | i);
    wait_bursts(1, 100);
    chk("t1_addr", last_awaddr, 32'h1000);
    chk("t1_len", last_len, 7);
    chk_stats("t1");

    // short burst via flush, then flush on empty FIFO
    b0 = n_bursts;
    for (int i = 0; i < 3; i++) push(64'hF00D_0000 | i);
    repeat (5) @(posedge clk);
    #1;
    chk("t2_no_early_burst", n_bursts, b0);
    pulse_flush();
    wait_done(1, 100);
    chk("t2_addr", last_awaddr, 32'h1040);
    chk("t2_len", last_len, 2);
    chk("t2_done_timing", last_done_cyc, last_wlast_cyc + 1);
    b0 = n_bursts;
    cf = cyc; flush = 1;
    @(posedge clk); #1;
    flush = 0;
    wait_done(2, 20);
    chk("t2_empty_done_timing", last_done_cyc, cf + 1);
    chk("t2_no_burst", n_bursts, b0);

    // backpressure fills the FIFO without loss
    pulse_fs(32'h1000);
    wready = 0;
    b0 = n_bursts;
    fork
      for (int i = 0; i < 20; i++) push(64'hBEEF_0000 | i);
      begin
        repeat (40) @(posedge clk);
        #1;
        chk("t3_full_ready", ready, 0);
        chk("t3_occupancy", mq.size(), 16);
        wready = 1;
      end
    join
    wait_bursts(b0 + 2, 200);
    chk("t3_addr0", aw_log[b0], 32'h1000);
    chk("t3_addr1", aw_log[b0 + 1], 32'h1040);
    pulse_flush();
    wait_done(3, 200);
    chk("t3_drained", mq.size(), 0);

    // pointer wrap
    pulse_fs(32'hFFFF_FFC0);
    b0 = n_bursts;
    for (int i = 0; i < 16; i++) push({$urandom, $urandom});
    wait_bursts(b0 + 2, 200);
    chk("t4_addr0", aw_log[b0], 32'hFFFF_FFC0);
    chk("t4_addr1", aw_log[b0 + 1], 32'h0);

    // frameStart during DATA is deferred
    pulse_fs(32'h3000);
    b0 = n_bursts;
    wready = 0;
    for (int i = 0; i < 8; i++) push({$urandom, $urandom});
    for (int c = 0; c < 50 && !wvalid; c++) begin @(posedge clk); #1; end
    chk("t5_in_data", wvalid, 1);
    pulse_fs(32'h2000);
    wready = 1;
    for (int i = 0; i < 8; i++) push({$urandom, $urandom});
    wait_bursts(b0 + 2, 200);
    chk("t5_old_addr", aw_log[b0], 32'h3000);
    chk("t5_new_addr", aw_log[b0 + 1], 32'h2000);
    @(posedge clk); #1;
    chk_stats("t5");

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      valid   = ($urandom_range(0, 1) == 1);
      payload = {$urandom, $urandom};
      wready  = ($urandom_range(0, 9) < 7);
      awready = ($urandom_range(0, 9) < 7);
      flush   = ($urandom_range(0, 49) == 0);
      fs      = ($urandom_range(0, 99) == 0);
      base    = $urandom & 32'hFFFF_FFC0;
      @(posedge clk); #1;
    end
    valid = 0; flush = 0; fs = 0; wready = 1; awready = 1;
    repeat (50) @(posedge clk);
    #1;
    b0 = n_done;
    pulse_flush();
    wait_done(b0 + 1, 300);
    chk("rand_drained", mq.size(), 0);
    @(posedge clk); #1;
    chk_stats("rand");

    // reset in the middle of a burst
    pulse_fs(32'h1000);
    wready = 0;
    for (int i = 0; i < 8; i++) push(64'hDEAD_0000 | i);
    for (int c = 0; c < 50 && !wvalid; c++) begin @(posedge clk); #1; end
    wready = 1;
    repeat (3) @(posedge clk);
    #1;
    mon_en = 0; rst_n = 0;
    @(posedge clk); #1;
    chk("t7_awvalid", awvalid, 0);
    chk("t7_wvalid", wvalid, 0);
    chk("t7_flushdone", flush_done, 0);
    chk("t7_ready", ready, 0);
    model_clear();
    chk_stats("t7");
    rst_n = 1;
    @(posedge clk); #1;
    mon_en = 1;
    chk("t7_ready_after", ready, 1);
    b0 = n_done;
    push(64'h1234_5678_9ABC_DEF0);
    pulse_flush();
    wait_done(b0 + 1, 100);
    chk("t7_addr", last_awaddr, 32'h0);
    chk("t7_len", last_len, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
